// File: rtl/mem_access_unit_if.sv
// Request / data-memory bus / response bundle for mem_access_unit.
// master: the requester plus the memory (the environment around the unit).
// slave:  the unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [7:0]        req_wmask;
  logic [63:0]       req_wdata;
  logic [1:0]        req_ldsize;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  logic              resp_valid;
  logic [63:0]       resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wmask, req_wdata, req_ldsize,
    input  req_ready,
    input  mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output mem_ready, mem_rdata,
    input  resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wmask, req_wdata, req_ldsize,
    output req_ready,
    output mem_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  mem_ready, mem_rdata,
    output resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store endpoint: one request per handshake, lane-aligned beats on a
// 64-bit word-aligned data-memory bus, raw right-justified load data back.
// Feature macro MISALIGN_SPLIT_EN: when defined, word-crossing accesses are
// split into two beats; when undefined they are rejected with resp_err and
// the second-beat state and upper alignment datapath do not exist.
module mem_access_unit #(
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  mem_access_unit_if.slave bus
);

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, RESP = 2'd3} state_e;
`endif

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

  // Store byte count from the right-justified mask; 0x7F and 0xFF both mean 8.
  function automatic logic [3:0] store_bytes(input logic [7:0] wmask);
    case (wmask)
      8'h01:   store_bytes = 4'd1;
      8'h03:   store_bytes = 4'd2;
      8'h0F:   store_bytes = 4'd4;
      default: store_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [3:0] nbytes);
    case (nbytes)
      4'd1:    byte_mask = 8'h01;
      4'd2:    byte_mask = 8'h03;
      4'd4:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] bit_mask(input logic [7:0] bmask);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{bmask[i]}};
    end
    return m;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [3:0]        n_q, n_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [63:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [3:0]        req_n_s;
  logic [2:0]        off_s;
  logic [ADDR_W-1:0] base_addr_s;
  logic              timeout_s;
  logic [63:0]       load_data_s;

  assign req_n_s     = bus.req_wen ? store_bytes(bus.req_wmask) : (4'd1 << bus.req_ldsize);
  assign off_s       = addr_q[2:0];
  assign base_addr_s = {addr_q[ADDR_W-1:3], 3'b000};
  assign timeout_s   = ((cnt_q + 16'd1) == TO_LIMIT);

`ifdef MISALIGN_SPLIT_EN
  logic [63:0]  rdata0_q, rdata0_d;
  logic [15:0]  mask16_s;
  logic [127:0] data128_s;
  logic [127:0] rd_word_s;
  logic         split_s;

  assign mask16_s    = {8'h00, byte_mask(n_q)} << off_s;
  assign data128_s   = {64'h0, wdata_q} << {off_s, 3'b000};
  assign split_s     = (({2'b00, off_s} + {1'b0, n_q}) > 5'd8);
  // In BEAT1 the first beat's word is already captured; otherwise only one word exists.
  assign rd_word_s   = (state_q == BEAT1) ? {bus.mem_rdata, rdata0_q} : {64'h0, bus.mem_rdata};
  assign load_data_s = 64'(rd_word_s >> {off_s, 3'b000}) & bit_mask(byte_mask(n_q));
`else
  logic [7:0]  mask8_s;
  logic [63:0] data64_s;
  logic        req_cross_s;

  assign mask8_s     = byte_mask(n_q) << off_s;
  assign data64_s    = wdata_q << {off_s, 3'b000};
  assign req_cross_s = (({2'b00, bus.req_addr[2:0]} + {1'b0, req_n_s}) > 5'd8);
  assign load_data_s = (bus.mem_rdata >> {off_s, 3'b000}) & bit_mask(byte_mask(n_q));
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;

  // Bus beat fields decoded from the registered request; zero outside a beat.
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_wmask = 8'h00;
    bus.mem_wdata = 64'h0;
    case (state_q)
      BEAT0: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = base_addr_s;
        bus.mem_wen   = wen_q;
`ifdef MISALIGN_SPLIT_EN
        bus.mem_wmask = wen_q ? mask16_s[7:0] : 8'h00;
        bus.mem_wdata = wen_q ? data128_s[63:0] : 64'h0;
`else
        bus.mem_wmask = wen_q ? mask8_s : 8'h00;
        bus.mem_wdata = wen_q ? data64_s : 64'h0;
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        bus.mem_valid = 1'b1;
        bus.mem_addr  = base_addr_s + ADDR_W'(4'd8);
        bus.mem_wen   = wen_q;
        bus.mem_wmask = wen_q ? mask16_s[15:8] : 8'h00;
        bus.mem_wdata = wen_q ? data128_s[127:64] : 64'h0;
      end
`endif
      default: begin
        bus.mem_valid = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept, beat completion / timeout, one-cycle response.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    resp_data_d = 64'h0;
    resp_err_d  = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    rdata0_d    = rdata0_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wen_d   = bus.req_wen;
          wdata_d = bus.req_wdata;
          n_d     = req_n_s;
          cnt_d   = 16'd0;
`ifdef MISALIGN_SPLIT_EN
          state_d = BEAT0;
`else
          if (req_cross_s) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d = BEAT0;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        if (bus.mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
          rdata0_d = bus.mem_rdata;
          if (split_s) begin
            state_d = BEAT1;
            cnt_d   = 16'd0;
          end else begin
            state_d     = RESP;
            resp_data_d = wen_q ? 64'h0 : load_data_s;
          end
`else
          state_d     = RESP;
          resp_data_d = wen_q ? 64'h0 : load_data_s;
`endif
        end else if (timeout_s) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        if (bus.mem_ready) begin
          state_d     = RESP;
          resp_data_d = wen_q ? 64'h0 : load_data_s;
        end else if (timeout_s) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; async reset abandons any in-flight access.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= 64'h0;
      n_q         <= 4'd0;
      cnt_q       <= 16'd0;
      resp_data_q <= 64'h0;
      resp_err_q  <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      rdata0_q    <= 64'h0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
`ifdef MISALIGN_SPLIT_EN
      rdata0_q    <= rdata0_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of aligned accesses, then
// hand-written word-crossing, timeout and reset-mid-beat sequences.
// Beat and response expectations are queued when a request is driven and
// checked by a monitor on the falling clock edge.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ready_en = 1'b1;
  logic [63:0] rd_even = 64'h0;
  logic [63:0] rd_odd = 64'h0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  mem_access_unit_if #(.ADDR_W(64)) bus ();

  mem_access_unit #(.ADDR_W(64), .TIMEOUT_CYC(4)) dut (
    .sys_clk (clk),
    .sys_rst (rst_n),
    .bus     (bus)
  );

  // Memory model: always-ready unless stalled; data picked by word parity.
  assign bus.mem_ready = ready_en;
  assign bus.mem_rdata = bus.mem_addr[3] ? rd_odd : rd_even;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  mask;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [1:0]  ldsize;
    logic [63:0] rd_even;
    logic [63:0] rd_odd;
    logic [63:0] baddr;
    logic [7:0]  bmask;
    logic [63:0] bwdata;
    logic [63:0] exp_data;
  } vec_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t mb;
  resp_t mr;
  vec_t  vecs[11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted beats and responses against the scoreboard queues.
  always @(negedge clk) begin
    if (bus.mem_valid && bus.mem_ready) begin
      if (beat_q.size() == 0) begin
        chk("unexpected_beat", bus.mem_valid, 1'b0);
      end else begin
        mb = beat_q.pop_front();
        chk("beat_addr", bus.mem_addr, mb.addr);
        chk("beat_wen", bus.mem_wen, mb.wen);
        chk("beat_wmask", bus.mem_wmask, mb.mask);
        chk("beat_wdata", bus.mem_wdata, mb.wdata);
      end
    end
    if (bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", bus.resp_valid, 1'b0);
      end else begin
        mr = resp_q.pop_front();
        chk("resp_data", bus.resp_data, mr.data);
        chk("resp_err", bus.resp_err, mr.err);
        chk("resp_cycle", cyc, mr.due);
      end
    end
  end

  task automatic do_req(input logic [63:0] addr, input logic wen, input logic [7:0] wmask,
                        input logic [63:0] wdata, input logic [1:0] ldsize,
                        input logic expect_resp, input logic [63:0] exp_data,
                        input logic exp_err, input int lat);
    int t0;
    bit got;
    resp_t r;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("req_ready_wait", got, 1'b1);
    if (got) begin
      bus.req_addr   = addr;
      bus.req_wen    = wen;
      bus.req_wmask  = wmask;
      bus.req_wdata  = wdata;
      bus.req_ldsize = ldsize;
      bus.req_valid  = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      if (expect_resp) begin
        r.data = exp_data;
        r.err  = exp_err;
        r.due  = t0 + lat;
        resp_q.push_back(r);
      end
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0) && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("drain", resp_q.size() + beat_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic cross_req(input logic [63:0] addr, input logic wen, input logic [7:0] wmask,
                           input logic [63:0] wdata, input logic [1:0] ldsize,
                           input logic [63:0] b0a, input logic [7:0] b0m, input logic [63:0] b0d,
                           input logic [63:0] b1a, input logic [7:0] b1m, input logic [63:0] b1d,
                           input logic [63:0] exp_data);
`ifdef MISALIGN_SPLIT_EN
    beat_q.push_back('{b0a, wen, b0m, b0d});
    beat_q.push_back('{b1a, wen, b1m, b1d});
    do_req(addr, wen, wmask, wdata, ldsize, 1'b1, exp_data, 1'b0, 3);
    wait_drain();
`else
    int vc;
    vc = 0;
    do_req(addr, wen, wmask, wdata, ldsize, 1'b1, 64'h0, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.mem_valid) vc++;
    end
    chk("cross_no_beat", vc, 0);
    chk("cross_unused", {b0a, b0m, b0d, b1a, b1m, b1d, exp_data} != '0, 1'b1);
    wait_drain();
`endif
  endtask

  initial begin
    int vc;
    vecs[0]  = '{64'h1004, 1'b1, 8'h0F, 64'hAABBCCDD, 2'd0, 64'h0, 64'h0,
                 64'h1000, 8'hF0, 64'hAABBCCDD_00000000, 64'h0};
    vecs[1]  = '{64'h2003, 1'b0, 8'h00, 64'h0, 2'd0, 64'h11223344_55667788, 64'hCAFEF00D_DEADBEEF,
                 64'h2000, 8'h00, 64'h0, 64'h55};
    vecs[2]  = '{64'h2006, 1'b0, 8'h00, 64'h0, 2'd1, 64'h11223344_55667788, 64'hCAFEF00D_DEADBEEF,
                 64'h2000, 8'h00, 64'h0, 64'h1122};
    vecs[3]  = '{64'h2004, 1'b0, 8'h00, 64'h0, 2'd2, 64'h11223344_55667788, 64'hCAFEF00D_DEADBEEF,
                 64'h2000, 8'h00, 64'h0, 64'h11223344};
    vecs[4]  = '{64'h2008, 1'b0, 8'h00, 64'h0, 2'd3, 64'h11223344_55667788, 64'hCAFEF00D_DEADBEEF,
                 64'h2008, 8'h00, 64'h0, 64'hCAFEF00D_DEADBEEF};
    vecs[5]  = '{64'h5001, 1'b1, 8'h01, 64'h11223344_556677EE, 2'd0, 64'h0, 64'h0,
                 64'h5000, 8'h02, 64'h22334455_6677EE00, 64'h0};
    vecs[6]  = '{64'h6002, 1'b1, 8'h03, 64'hBEEF, 2'd0, 64'h0, 64'h0,
                 64'h6000, 8'h0C, 64'h00000000_BEEF0000, 64'h0};
    vecs[7]  = '{64'h7000, 1'b1, 8'hFF, 64'h01234567_89ABCDEF, 2'd0, 64'h0, 64'h0,
                 64'h7000, 8'hFF, 64'h01234567_89ABCDEF, 64'h0};
    vecs[8]  = '{64'h7008, 1'b1, 8'h7F, 64'h0F1E2D3C_4B5A6978, 2'd0, 64'h0, 64'h0,
                 64'h7008, 8'hFF, 64'h0F1E2D3C_4B5A6978, 64'h0};
    vecs[9]  = '{64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'h00, 64'h0, 2'd0, 64'h0, 64'h99887766_55443322,
                 64'hFFFFFFFF_FFFFFFF8, 8'h00, 64'h0, 64'h99};
    vecs[10] = '{64'h2000, 1'b0, 8'h00, 64'h0, 2'd1, 64'h11223344_55667788, 64'h0,
                 64'h2000, 8'h00, 64'h0, 64'h7788};

    bus.req_valid  = 1'b0;
    bus.req_addr   = 64'h0;
    bus.req_wen    = 1'b0;
    bus.req_wmask  = 8'h00;
    bus.req_wdata  = 64'h0;
    bus.req_ldsize = 2'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", bus.mem_valid, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 64'h0);
    chk("rst_mem_wmask", bus.mem_wmask, 8'h00);
    chk("rst_mem_wdata", bus.mem_wdata, 64'h0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_data", bus.resp_data, 64'h0);
    chk("rst_resp_err", bus.resp_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);

    // Aligned, single-beat accesses
    for (int k = 0; k < 11; k++) begin
      rd_even = vecs[k].rd_even;
      rd_odd  = vecs[k].rd_odd;
      beat_q.push_back('{vecs[k].baddr, vecs[k].wen, vecs[k].bmask, vecs[k].bwdata});
      do_req(vecs[k].addr, vecs[k].wen, vecs[k].wmask, vecs[k].wdata, vecs[k].ldsize,
             1'b1, vecs[k].exp_data, 1'b0, 2);
      wait_drain();
    end

    // Word-crossing accesses
    cross_req(64'h3006, 1'b1, 8'h7F, 64'h08070605_04030201, 2'd0,
              64'h3000, 8'hC0, 64'h02010000_00000000,
              64'h3008, 8'h3F, 64'h00000807_06050403, 64'h0);
    cross_req(64'h5007, 1'b1, 8'h03, 64'hBEEF, 2'd0,
              64'h5000, 8'h80, 64'hEF000000_00000000,
              64'h5008, 8'h01, 64'h00000000_000000BE, 64'h0);
    rd_even = 64'h11112222_33334444;
    rd_odd  = 64'h55556666_77778888;
    cross_req(64'h4004, 1'b0, 8'h00, 64'h0, 2'd3,
              64'h4000, 8'h00, 64'h0, 64'h4008, 8'h00, 64'h0, 64'h77778888_11112222);
    cross_req(64'h4006, 1'b0, 8'h00, 64'h0, 2'd2,
              64'h4000, 8'h00, 64'h0, 64'h4008, 8'h00, 64'h0, 64'h88881111);
    cross_req(64'hFFFFFFFF_FFFFFFFF, 1'b0, 8'h00, 64'h0, 2'd1,
              64'hFFFFFFFF_FFFFFFF8, 8'h00, 64'h0, 64'h0, 8'h00, 64'h0, 64'h4455);

    // Timeout: mem_ready never comes
    ready_en = 1'b0;
    do_req(64'h8000, 1'b0, 8'h00, 64'h0, 2'd2, 1'b1, 64'h0, 1'b1, 5);
    vc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.mem_valid) vc++;
      if (bus.resp_valid) break;
    end
    chk("timeout_valid_cycles", vc, 4);
    @(negedge clk);
    chk("timeout_req_ready", bus.req_ready, 1'b1);
    chk("timeout_mem_valid_low", bus.mem_valid, 1'b0);
    ready_en = 1'b1;
    wait_drain();

    // mem_ready arriving on the last allowed cycle completes normally
    ready_en = 1'b0;
    rd_even  = 64'h01234567_89ABCDEF;
    beat_q.push_back('{64'h8000, 1'b0, 8'h00, 64'h0});
    do_req(64'h8004, 1'b0, 8'h00, 64'h0, 2'd2, 1'b1, 64'h01234567, 1'b0, 5);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ready_en = 1'b1;
    wait_drain();

    // Reset in the middle of an access
`ifdef MISALIGN_SPLIT_EN
    beat_q.push_back('{64'h3000, 1'b1, 8'hC0, 64'h02010000_00000000});
    do_req(64'h3006, 1'b1, 8'h7F, 64'h08070605_04030201, 2'd0, 1'b0, 64'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    ready_en = 1'b0;
    chk("mid_beat1_addr", bus.mem_addr, 64'h3008);
`else
    ready_en = 1'b0;
    do_req(64'h8000, 1'b0, 8'h00, 64'h0, 2'd2, 1'b0, 64'h0, 1'b0, 0);
    chk("mid_beat0_addr", bus.mem_addr, 64'h8000);
`endif
    #2;
    chk("mid_beat_valid", bus.mem_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", bus.mem_valid, 1'b0);
    chk("async_rst_resp_valid", bus.resp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    ready_en = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_no_resp", bus.resp_valid, 1'b0);

    chk("beat_q_empty", beat_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
